// File: rtl/vga_vram_arbiter.sv
// Shares one synchronous VRAM port between display prefetch and a pixel writer and unpacks
// fetched words into a registered pixel stream. Define VGA_ARB_VBLANK_ONLY_EN to restrict writes to VBLANK.
module vga_vram_arbiter #(
    parameter int H_ACTIVE = 640,
    parameter int H_TOTAL  = 800,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525,
    parameter int PIX_W    = 4,
    parameter int ADDR_W   = 17,
    localparam int DATA_W  = 4 * PIX_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [9:0]        i_Col,
    input  logic [9:0]        i_Row,
    input  logic              i_Wr_Valid,
    input  logic [ADDR_W-1:0] i_Wr_Addr,
    input  logic [DATA_W-1:0] i_Wr_Data,
    output logic              o_Wr_Ready,
    output logic              o_Mem_En,
    output logic              o_Mem_We,
    output logic [ADDR_W-1:0] o_Mem_Addr,
    output logic [DATA_W-1:0] o_Mem_Wdata,
    input  logic [DATA_W-1:0] i_Mem_Rdata,
    output logic [PIX_W-1:0]  o_Pixel,
    output logic              o_Pixel_Valid,
    output logic              o_Drop
);

    localparam int WPL = H_ACTIVE / 4;
    localparam logic [9:0] H_ACT_C       = 10'(H_ACTIVE);
    localparam logic [9:0] H_FETCH_END_C = 10'(H_ACTIVE - 4);
    localparam logic [9:0] H_W0_C        = 10'(H_TOTAL - 4);
    localparam logic [9:0] H_LAST_C      = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_ACT_C       = 10'(V_ACTIVE);
    localparam logic [9:0] V_ACT_LAST_C  = 10'(V_ACTIVE - 1);
    localparam logic [9:0] V_LAST_C      = 10'(V_TOTAL - 1);
    localparam logic [ADDR_W-1:0] WPL_C   = ADDR_W'(WPL);
    localparam logic [ADDR_W-1:0] WORDS_C = ADDR_W'(WPL * V_ACTIVE);

    typedef enum logic {
        ST_SCAN   = 1'b0,
        ST_VBLANK = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic               enter_vblank_s;
    logic               fetch_slot_s;
    logic               fetch_w0_s;
    logic [9:0]         fetch_row_s;
    logic [7:0]         fetch_word_s;
    logic [9:0]         next_row_s;
    logic [ADDR_W-1:0]  fetch_addr_s;
    logic               wr_fire_s;
    logic               wr_in_range_s;
    logic               active_s;
    logic [PIX_W-1:0]   pixel_s;
    logic               rd_pend_r;
    logic               rd_pend_w0_r;
    logic               rd_valid_r;
    logic               rd_valid_w0_r;
    logic [DATA_W-1:0]  shadow_r;
    logic [DATA_W-1:0]  cur_r;
    logic               primed_r;

    function automatic logic [PIX_W-1:0] lane_sel(input logic [DATA_W-1:0] word, input logic [1:0] lane);
        case (lane)
            2'd0:    lane_sel = word[0*PIX_W +: PIX_W];
            2'd1:    lane_sel = word[1*PIX_W +: PIX_W];
            2'd2:    lane_sel = word[2*PIX_W +: PIX_W];
            default: lane_sel = word[3*PIX_W +: PIX_W];
        endcase
    endfunction

    assign next_row_s = (i_Row == V_LAST_C) ? 10'd0 : (i_Row + 10'd1);

    // Fetch slot decode: next word of the current line, or word 0 of the next visible line.
    always_comb begin
        fetch_slot_s = 1'b0;
        fetch_w0_s   = 1'b0;
        fetch_row_s  = i_Row;
        fetch_word_s = 8'd0;
        if ((i_Col[1:0] == 2'b00) && (i_Col < H_FETCH_END_C) && (i_Row < V_ACT_C)) begin
            fetch_slot_s = 1'b1;
            fetch_word_s = i_Col[9:2] + 8'd1;
        end else if ((i_Col == H_W0_C) && (next_row_s < V_ACT_C)) begin
            fetch_slot_s = 1'b1;
            fetch_w0_s   = 1'b1;
            fetch_row_s  = next_row_s;
        end else begin
            fetch_slot_s = 1'b0;
        end
    end

    assign fetch_addr_s  = (ADDR_W'(fetch_row_s) * WPL_C) + ADDR_W'(fetch_word_s);
    assign wr_in_range_s = (i_Wr_Addr < WORDS_C);
    assign active_s      = (i_Col < H_ACT_C) && (i_Row < V_ACT_C);
    assign pixel_s       = (i_Col[1:0] == 2'b00) ? lane_sel(shadow_r, 2'b00) : lane_sel(cur_r, i_Col[1:0]);

`ifdef VGA_ARB_VBLANK_ONLY_EN
    assign o_Wr_Ready = RST_N && !fetch_slot_s && (state_r == ST_VBLANK);
`else
    assign o_Wr_Ready = RST_N && !fetch_slot_s;
`endif
    assign wr_fire_s = i_Wr_Valid && o_Wr_Ready;

    // Frame state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= ST_VBLANK;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Frame state transitions at the last column of the last active / last total row.
    always_comb begin
        state_nxt_s    = state_r;
        enter_vblank_s = 1'b0;
        case (state_r)
            ST_SCAN: begin
                if ((i_Row == V_ACT_LAST_C) && (i_Col == H_LAST_C)) begin
                    state_nxt_s    = ST_VBLANK;
                    enter_vblank_s = 1'b1;
                end else begin
                    state_nxt_s = ST_SCAN;
                end
            end
            ST_VBLANK: begin
                if ((i_Row == V_LAST_C) && (i_Col == H_LAST_C)) begin
                    state_nxt_s = ST_SCAN;
                end else begin
                    state_nxt_s = ST_VBLANK;
                end
            end
            default: state_nxt_s = ST_VBLANK;
        endcase
    end

    // Memory request register; fetch has priority, out-of-range writes are swallowed.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            o_Mem_En    <= 1'b0;
            o_Mem_We    <= 1'b0;
            o_Mem_Addr  <= {ADDR_W{1'b0}};
            o_Mem_Wdata <= {DATA_W{1'b0}};
            o_Drop      <= 1'b0;
        end else begin
            if (fetch_slot_s) begin
                o_Mem_En    <= 1'b1;
                o_Mem_We    <= 1'b0;
                o_Mem_Addr  <= fetch_addr_s;
                o_Mem_Wdata <= {DATA_W{1'b0}};
            end else if (wr_fire_s && wr_in_range_s) begin
                o_Mem_En    <= 1'b1;
                o_Mem_We    <= 1'b1;
                o_Mem_Addr  <= i_Wr_Addr;
                o_Mem_Wdata <= i_Wr_Data;
            end else begin
                o_Mem_En <= 1'b0;
                o_Mem_We <= 1'b0;
            end
            o_Drop <= wr_fire_s && !wr_in_range_s;
        end
    end

    // Read-return tracking: data is on i_Mem_Rdata two cycles after the fetch slot.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_pend_r     <= 1'b0;
            rd_pend_w0_r  <= 1'b0;
            rd_valid_r    <= 1'b0;
            rd_valid_w0_r <= 1'b0;
        end else begin
            rd_pend_r     <= fetch_slot_s;
            rd_pend_w0_r  <= fetch_w0_s;
            rd_valid_r    <= rd_pend_r;
            rd_valid_w0_r <= rd_pend_w0_r;
        end
    end

    // Unpack path: shadow capture, word hand-over at lane 0, registered pixel out.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            shadow_r      <= {DATA_W{1'b0}};
            cur_r         <= {DATA_W{1'b0}};
            primed_r      <= 1'b0;
            o_Pixel       <= {PIX_W{1'b0}};
            o_Pixel_Valid <= 1'b0;
        end else begin
            if (rd_valid_r) begin
                shadow_r <= i_Mem_Rdata;
            end
            if (active_s && (i_Col[1:0] == 2'b00)) begin
                cur_r <= shadow_r;
            end
            if (enter_vblank_s) begin
                primed_r <= 1'b0;
            end else if (rd_valid_r && rd_valid_w0_r) begin
                primed_r <= 1'b1;
            end
            o_Pixel       <= pixel_s;
            o_Pixel_Valid <= active_s && primed_r;
        end
    end

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Randomized bench for vga_vram_arbiter: drives timing counters and a writer, emulates the VRAM,
// and checks every cycle against a frame-level model plus a few hand-computed expectations.
module tb_vga_vram_arbiter;

    localparam int H_ACTIVE = 640;
    localparam int H_TOTAL  = 800;
    localparam int V_ACTIVE = 480;
    localparam int V_TOTAL  = 525;
    localparam int WPL      = H_ACTIVE / 4;
    localparam int WORDS    = WPL * V_ACTIVE;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [9:0]  col_in, row_in;
    logic        wr_valid;
    logic [16:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_ready, mem_en, mem_we, pix_valid, drop;
    logic [16:0] mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic [3:0]  pixel;

    int col, row;
    assign col_in = 10'(col);
    assign row_in = 10'(row);

    always #5 CLK = ~CLK;

    vga_vram_arbiter dut (
        .CLK(CLK), .RST_N(RST_N), .i_Col(col_in), .i_Row(row_in),
        .i_Wr_Valid(wr_valid), .i_Wr_Addr(wr_addr), .i_Wr_Data(wr_data), .o_Wr_Ready(wr_ready),
        .o_Mem_En(mem_en), .o_Mem_We(mem_we), .o_Mem_Addr(mem_addr), .o_Mem_Wdata(mem_wdata),
        .i_Mem_Rdata(mem_rdata), .o_Pixel(pixel), .o_Pixel_Valid(pix_valid), .o_Drop(drop)
    );

    // Synchronous single-port VRAM, cleared on the first clock.
    logic [15:0] vram [0:WORDS-1];
    logic        vram_init = 1'b0;
    always @(posedge CLK) begin
        if (!vram_init) begin
            for (int i = 0; i < WORDS; i++) vram[i] <= 16'h0000;
            mem_rdata <= 16'h0000;
            vram_init <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) vram[mem_addr] <= mem_wdata;
            else        mem_rdata <= vram[mem_addr];
        end
    end

    // Reference model state
    logic [15:0] mmem [0:WORDS-1];
    logic [15:0] snap [0:WPL-1];
    int  primed_row;
    bit  m_vblank;
    bit  exp_en, exp_we, exp_drop, exp_pv;
    int  exp_addr, exp_wdata, exp_pix;
    bit  rnd_en;
    int  nerr, nchk;

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            if (nerr <= 40)
                $display("FAIL %s: got %0d expected %0d (row %0d col %0d)", name, act, exp, row, col);
        end
    endtask

    function automatic void m_slot(input int c, input int r, output bit s, output int a,
                                   output bit w0, output int nr);
        nr = (r == V_TOTAL - 1) ? 0 : r + 1;
        s = 1'b0; a = 0; w0 = 1'b0;
        if (c % 4 == 0 && c < H_ACTIVE - 4 && r < V_ACTIVE) begin
            s = 1'b1; a = r * WPL + c / 4 + 1;
        end else if (c == H_TOTAL - 4 && nr < V_ACTIVE) begin
            s = 1'b1; w0 = 1'b1; a = nr * WPL;
        end
    endfunction

    function automatic int rnd_addr();
        int k;
        k = int'($urandom_range(7, 0));
        case (k)
            0, 1, 2: return int'($urandom_range(2079, 1));
            3, 4:    return int'($urandom_range(16479, 15840));
            5:       return int'($urandom_range(131071, 76800));
            default: return int'($urandom_range(WORDS - 1, 1));
        endcase
    endfunction

    task automatic model_reset();
        exp_en = 1'b0; exp_we = 1'b0; exp_drop = 1'b0; exp_pv = 1'b0;
        exp_addr = 0; exp_wdata = 0; exp_pix = 0;
        primed_row = -1;
        m_vblank = 1'b1;
    endtask

    task automatic step();
        bit s, w0, rdy, fire, inr;
        int a, nr;
        @(negedge CLK);
        m_slot(col, row, s, a, w0, nr);
`ifdef VGA_ARB_VBLANK_ONLY_EN
        rdy = (RST_N == 1'b1) && !s && m_vblank;
`else
        rdy = (RST_N == 1'b1) && !s;
`endif
        chk("wr_ready", int'(wr_ready), int'(rdy));
        chk("mem_en", int'(mem_en), int'(exp_en));
        chk("mem_we", int'(mem_we), int'(exp_we));
        if (exp_en) chk("mem_addr", int'(mem_addr), exp_addr);
        if (exp_en && exp_we) chk("mem_wdata", int'(mem_wdata), exp_wdata);
        chk("drop", int'(drop), int'(exp_drop));
        chk("pix_valid", int'(pix_valid), int'(exp_pv));
        if (exp_pv) chk("pixel", int'(pixel), exp_pix);
        @(posedge CLK);
        fire = 1'b0;
        if (RST_N == 1'b1) begin
            fire = wr_valid && rdy;
            inr  = int'(wr_addr) < WORDS;
            exp_pv = (col < H_ACTIVE) && (row < V_ACTIVE) && (primed_row == row);
            if (col < H_ACTIVE) exp_pix = int'(snap[col / 4] >> (4 * (col % 4))) & 15;
            if (s) begin
                exp_en = 1'b1; exp_we = 1'b0; exp_addr = a;
                snap[w0 ? 0 : col / 4 + 1] = mmem[a];
                if (w0) primed_row = nr;
            end else if (fire && inr) begin
                exp_en = 1'b1; exp_we = 1'b1; exp_addr = int'(wr_addr); exp_wdata = int'(wr_data);
                mmem[wr_addr] = wr_data;
            end else begin
                exp_en = 1'b0; exp_we = 1'b0;
            end
            exp_drop = fire && !inr;
            if (row == V_ACTIVE - 1 && col == H_TOTAL - 1) m_vblank = 1'b1;
            else if (row == V_TOTAL - 1 && col == H_TOTAL - 1) m_vblank = 1'b0;
        end else begin
            model_reset();
        end
        #1;
        col = col + 1;
        if (col == H_TOTAL) begin
            col = 0;
            row = (row == V_TOTAL - 1) ? 0 : row + 1;
        end
        if (fire) wr_valid = 1'b0;
        if (rnd_en && !wr_valid && $urandom_range(1, 0) == 1) begin
            wr_valid = 1'b1;
            wr_addr  = 17'(rnd_addr());
            wr_data  = 16'($urandom);
        end
    endtask

    task automatic run_until(input int r, input int c);
        int n;
        n = 0;
        while (!(row == r && col == c) && n < 30000) begin
            step();
            n++;
        end
        nchk++;
        if (!(row == r && col == c)) begin
            nerr++;
            $display("FAIL run_until: stuck at row %0d col %0d wanted row %0d col %0d", row, col, r, c);
        end
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        wr_valid = 1'b0;
        model_reset();
        #1;
        chk("rst_ready", int'(wr_ready), 0);
        chk("rst_mem_en", int'(mem_en), 0);
        chk("rst_mem_we", int'(mem_we), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_mem_wdata", int'(mem_wdata), 0);
        chk("rst_pixel", int'(pixel), 0);
        chk("rst_pix_valid", int'(pix_valid), 0);
        chk("rst_drop", int'(drop), 0);
    endtask

    task automatic direct_write(input int a, input int d, input int exp_ready);
        wr_valid = 1'b1;
        wr_addr  = 17'(a);
        wr_data  = 16'(d);
        #1;
        chk("dir_ready", int'(wr_ready), exp_ready);
    endtask

    initial begin
        nerr = 0; nchk = 0; rnd_en = 1'b0;
        RST_N = 1'b0; wr_valid = 1'b0; wr_addr = 17'd0; wr_data = 16'd0;
        col = 0; row = 0;
        for (int i = 0; i < WORDS; i++) mmem[i] = 16'h0000;
        for (int i = 0; i < WPL; i++) snap[i] = 16'h0000;
        model_reset();
        @(posedge CLK);
        #1;
        do_reset();
        repeat (3) step();
        row = 523; col = 0;
        repeat (2) step();
        RST_N = 1'b1;

        // Preload word 0 of row 0 through the writer during blanking.
        run_until(523, 10);
        direct_write(0, 16'h4321, 1);
        step();
        chk("pre_en", int'(mem_en), 1);
        chk("pre_we", int'(mem_we), 1);
        chk("pre_addr", int'(mem_addr), 0);
        chk("pre_wdata", int'(mem_wdata), 16'h4321);

        rnd_en = 1'b1;
        run_until(524, 700);
        rnd_en = 1'b0;
        run_until(0, 0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("scan_pixel", int'(pixel), k + 1);
            chk("scan_valid", int'(pix_valid), 1);
        end

        // Fetch slot at row 10 col 8 beats a waiting writer.
        rnd_en = 1'b1;
        run_until(9, 0);
        rnd_en = 1'b0;
        run_until(10, 8);
        direct_write(1234, 16'hBEEF, 0);
        step();
        chk("slot_en", int'(mem_en), 1);
        chk("slot_we", int'(mem_we), 0);
        chk("slot_addr", int'(mem_addr), 10 * 160 + 3);
        #1;
`ifdef VGA_ARB_VBLANK_ONLY_EN
        chk("scan_no_grant", int'(wr_ready), 0);
        wr_valid = 1'b0;
`else
        chk("after_slot_ready", int'(wr_ready), 1);
        step();
        chk("held_en", int'(mem_en), 1);
        chk("held_we", int'(mem_we), 1);
        chk("held_addr", int'(mem_addr), 1234);
        chk("held_wdata", int'(mem_wdata), 16'hBEEF);
`endif
        rnd_en = 1'b1;
        run_until(12, 0);

        // Reset in the middle of row 100.
        do_reset();
        repeat (2) step();
        row = 99; col = 700;
        repeat (2) step();
        RST_N = 1'b1;
        run_until(100, 300);
        do_reset();
        repeat (3) step();
        RST_N = 1'b1;
        run_until(100, 600);
        chk("midline_invalid", int'(pix_valid), 0);
        run_until(101, 0);
        step();
        chk("reprimed_valid", int'(pix_valid), 1);

        // Vertical blanking: write after reset, then an out-of-range write.
        do_reset();
        repeat (2) step();
        row = 478; col = 700;
        step();
        RST_N = 1'b1;
        run_until(489, 0);
        rnd_en = 1'b0;
        run_until(490, 10);
        direct_write(5, 16'hA5C3, 1);
        step();
        chk("vb_en", int'(mem_en), 1);
        chk("vb_we", int'(mem_we), 1);
        chk("vb_addr", int'(mem_addr), 5);
        chk("vb_wdata", int'(mem_wdata), 16'hA5C3);
        run_until(491, 1);
        direct_write(76800, 16'h1111, 1);
        step();
        chk("oor_en", int'(mem_en), 0);
        chk("oor_drop", int'(drop), 1);
        step();
        chk("oor_drop_once", int'(drop), 0);
        repeat (20) step();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
